adc_sample_sequencer: RTL



---
 rtl/adc_sample_sequencer_pkg.sv | 20 ++
 rtl/adc_tick_gen.sv | 42 ++++
 rtl/adc_sample_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/adc_sample_sequencer_pkg.sv
// Shared definitions for the ADC sample sequencer: FSM state encoding and
// default parameter values used by the top level and the tick generator.
package adc_sample_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_QUIET
   } seq_state_e;

   localparam int DIV_HALF_DEF    = 71;
   localparam int NUM_CH_DEF      = 4;
   localparam int CH_W_DEF        = 2;
   localparam int FRAME_BITS_DEF  = 16;
   localparam int DATA_BITS_DEF   = 12;
   localparam int QUIET_TICKS_DEF = 2;

endpackage

// File: rtl/adc_tick_gen.sv
// Half-period tick generator for the ADC serial clock.
// Counts 0..DIV_HALF-1 and pulses tick_o on the last count. Held cleared
// while clr_i is high so the first tick after release lands exactly
// DIV_HALF clocks later.
//   clk_sys      in  system clock
//   reset_Clock  in  asynchronous active-high reset
//   clr_i        in  synchronous clear (sequencer idle)
//   tick_o       out one-cycle pulse every DIV_HALF clocks while not cleared
module adc_tick_gen #(
   parameter int DIV_HALF = adc_sample_sequencer_pkg::DIV_HALF_DEF
) (
   input  logic clk_sys,
   input  logic reset_Clock,
   input  logic clr_i,
   output logic tick_o
);

   localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
   localparam logic [DW-1:0] LAST = DW'(DIV_HALF - 1);

   logic [DW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + DW'(1);
      end
   end

   always_ff @(posedge clk_sys or posedge reset_Clock) begin
      if (reset_Clock) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/adc_sample_sequencer.sv
// Conversion sequencer for a 12-bit serial ADC behind an analog mux.
// Round-robins over the enabled channels, clocks a 16-bit frame in MSB
// first, and publishes each result with its channel tag as a valid pulse.
//   clk_sys       in  system clock
//   reset_Clock   in  asynchronous active-high reset
//   start         in  one-shot conversion request (honoured only when idle)
//   cont_en       in  continuous conversion enable
//   ch_mask       in  enabled channels, sampled at each selection
//   adc_miso      in  serial data from the ADC
//   adc_cs_n      out chip select, active low
//   adc_sclk      out serial clock, idles high
//   adc_ch_sel    out analog mux select
//   busy          out high whenever not idle
//   sample_valid  out one-cycle pulse per completed frame
//   sample_data   out result, held until the next pulse
//   sample_ch     out channel of sample_data
//   frame_err     out leading frame bits were not all zero (with sample_valid)
//
// state    | meaning
// ST_IDLE  | waiting for a request; selects the next channel in one cycle
// ST_SETUP | cs_n low, sclk high, one tick for the mux to settle
// ST_SHIFT | sclk toggles each tick, data captured on rising toggles
// ST_HOLD  | sclk high for one tick, then result is published
// ST_QUIET | cs_n high for QUIET_TICKS ticks between frames
module adc_sample_sequencer
   import adc_sample_sequencer_pkg::*;
#(
   parameter int DIV_HALF    = DIV_HALF_DEF,
   parameter int NUM_CH      = NUM_CH_DEF,
   parameter int CH_W        = CH_W_DEF,
   parameter int FRAME_BITS  = FRAME_BITS_DEF,
   parameter int DATA_BITS   = DATA_BITS_DEF,
   parameter int QUIET_TICKS = QUIET_TICKS_DEF
) (
   input  logic                 clk_sys,
   input  logic                 reset_Clock,
   input  logic                 start,
   input  logic                 cont_en,
   input  logic [NUM_CH-1:0]    ch_mask,
   input  logic                 adc_miso,
   output logic                 adc_cs_n,
   output logic                 adc_sclk,
   output logic [CH_W-1:0]      adc_ch_sel,
   output logic                 busy,
   output logic                 sample_valid,
   output logic [DATA_BITS-1:0] sample_data,
   output logic [CH_W-1:0]      sample_ch,
   output logic                 frame_err
);

   localparam int CNT_MAX = (FRAME_BITS > QUIET_TICKS) ? FRAME_BITS : QUIET_TICKS;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] LAST_QUIET = CNT_W'(QUIET_TICKS - 1);

   seq_state_e              state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    sclk_q, sclk_d;
   logic                    cs_n_q, cs_n_d;
   logic [FRAME_BITS-1:0]   shift_q, shift_d;
   logic [CH_W-1:0]         ch_sel_q, ch_sel_d;
   logic [CH_W-1:0]         last_ch_q, last_ch_d;
   logic                    valid_q, valid_d;
   logic [DATA_BITS-1:0]    data_q, data_d;
   logic [CH_W-1:0]         sch_q, sch_d;
   logic                    err_q, err_d;
   logic                    tick;

   // First enabled channel strictly after 'last', wrapping; 'last' itself is
   // the final candidate so a single enabled bit repeats.
   function automatic logic [CH_W-1:0] pick_next(input logic [CH_W-1:0] last,
                                                 input logic [NUM_CH-1:0] mask);
      logic [CH_W-1:0] res;
      logic            found;
      int              idx;
      res   = last;
      found = 1'b0;
      for (int i = 1; i <= NUM_CH; i++) begin
         idx = (int'(last) + i) % NUM_CH;
         if (!found && mask[idx]) begin
            res   = CH_W'(idx);
            found = 1'b1;
         end
      end
      return res;
   endfunction

   adc_tick_gen #(.DIV_HALF(DIV_HALF)) u_tick (
      .clk_sys     (clk_sys),
      .reset_Clock (reset_Clock),
      .clr_i       (state_q == ST_IDLE),
      .tick_o      (tick)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sclk_d    = sclk_q;
      shift_d   = shift_q;
      ch_sel_d  = ch_sel_q;
      last_ch_d = last_ch_q;
      valid_d   = 1'b0;
      data_d    = data_q;
      sch_d     = sch_q;
      err_d     = err_q;
      case (state_q)
         ST_IDLE: begin
            sclk_d = 1'b1;
            if ((start || cont_en) && (|ch_mask)) begin
               ch_sel_d  = pick_next(last_ch_q, ch_mask);
               last_ch_d = ch_sel_d;
               state_d   = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (tick) begin
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (tick) begin
               sclk_d = ~sclk_q;
               if (!sclk_q) begin
                  shift_d = {shift_q[FRAME_BITS-2:0], adc_miso};
                  if (cnt_q == LAST_BIT) begin
                     state_d = ST_HOLD;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
         end
         ST_HOLD: begin
            if (tick) begin
               valid_d = 1'b1;
               data_d  = shift_q[DATA_BITS-1:0];
               sch_d   = ch_sel_q;
               err_d   = |shift_q[FRAME_BITS-1:DATA_BITS];
               cnt_d   = '0;
               state_d = ST_QUIET;
            end
         end
         ST_QUIET: begin
            if (tick) begin
               if (cnt_q == LAST_QUIET) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Registered from next state so the pin never glitches on state decode.
      cs_n_d = !((state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD));
   end

   always_ff @(posedge clk_sys or posedge reset_Clock) begin
      if (reset_Clock) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         sclk_q    <= 1'b1;
         cs_n_q    <= 1'b1;
         shift_q   <= '0;
         ch_sel_q  <= '0;
         last_ch_q <= CH_W'(NUM_CH - 1);
         valid_q   <= 1'b0;
         data_q    <= '0;
         sch_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sclk_q    <= sclk_d;
         cs_n_q    <= cs_n_d;
         shift_q   <= shift_d;
         ch_sel_q  <= ch_sel_d;
         last_ch_q <= last_ch_d;
         valid_q   <= valid_d;
         data_q    <= data_d;
         sch_q     <= sch_d;
         err_q     <= err_d;
      end
   end

   assign adc_cs_n     = cs_n_q;
   assign adc_sclk     = sclk_q;
   assign adc_ch_sel   = ch_sel_q;
   assign busy         = (state_q != ST_IDLE);
   assign sample_valid = valid_q;
   assign sample_data  = data_q;
   assign sample_ch    = sch_q;
   assign frame_err    = err_q;

endmodule
